// File: rtl/divu_32by16.sv
// Purpose : unsigned 32-by-16 restoring divider, one quotient bit per clock.
// Latency : done 32 edges after the accepted start (or 1 edge for b=0 when DIVU_DBZ_FAST_EN).
// Backpr. : start is only accepted in IDLE; q/r/dbz hold until the next accepted start.
//
// Ports:
//   clk   - single clock, all state changes on its rising edge
//   reset - asynchronous, active-low
//   start - request, sampled only while idle; z/b are captured with it
//   z, b  - 32-bit unsigned dividend, 16-bit unsigned divisor
//   q, r  - registered quotient and remainder
//   busy  - high in RUN and DONE
//   done  - one-cycle pulse when q/r/dbz are valid
//   dbz   - divide-by-zero flag, valid with done
//
// Build option: define DIVU_DBZ_FAST_EN to finish a b=0 divide one edge after
// start instead of walking all 32 steps (results are identical).
module divu_32by16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] z,
  input  logic [15:0] b,
  output logic [31:0] q,
  output logic [15:0] r,
  output logic        busy,
  output logic        done,
  output logic        dbz
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef DIVU_DBZ_FAST_EN
  localparam logic FAST_DBZ = 1'b1;
`else
  localparam logic FAST_DBZ = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  // Dividend shifts out of the top while quotient bits shift in at the bottom,
  // so after 32 steps this register holds the quotient.
  logic [31:0] dvd_q, dvd_d;
  logic [15:0] div_q, div_d;
  logic [16:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] q_q, q_d;
  logic [15:0] r_q, r_d;
  logic        dbz_q, dbz_d;

  // One restoring step.
  logic [16:0] rem_sh;
  logic        q_bit;
  logic [16:0] rem_step;
  logic [31:0] dvd_step;

  always_comb begin
    rem_sh   = {rem_q[15:0], dvd_q[31]};
    q_bit    = (rem_sh >= {1'b0, div_q});
    rem_step = q_bit ? (rem_sh - {1'b0, div_q}) : rem_sh;
    dvd_step = {dvd_q[30:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = z;
          div_d   = b;
          rem_d   = 17'd0;
          cnt_d   = 5'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (FAST_DBZ && (div_q == 16'd0)) begin
          // Shortcut yields what 32 restoring steps with b=0 would produce.
          q_d     = 32'hFFFF_FFFF;
          r_d     = dvd_q[15:0];
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          dvd_d = dvd_step;
          rem_d = rem_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            q_d     = dvd_step;
            r_d     = rem_step[15:0];
            dbz_d   = (div_q == 16'd0);
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start is deliberately ignored here; it is honoured once back in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dvd_q   <= 32'd0;
      div_q   <= 16'd0;
      rem_q   <= 17'd0;
      cnt_q   <= 5'd0;
      q_q     <= 32'd0;
      r_q     <= 16'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_divu_32by16.sv
// Purpose : directed self-checking bench for divu_32by16.
// Latency : expects done 32 edges after the start edge (1 for b=0 with DIVU_DBZ_FAST_EN).
// Backpr. : start held high must only be accepted in IDLE.
module tb_divu_32by16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] z;
  logic [15:0] b;
  logic [31:0] q;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        dbz;

  int checks = 0;
  int errors = 0;

`ifdef DIVU_DBZ_FAST_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = 32;
`endif

  divu_32by16 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .z     (z),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are
  // sampled here, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one divide and wait (bounded) for done. lat = edges after the start
  // edge at which done was first seen, or -1 if it never came.
  task automatic launch(input logic [31:0] zz, input logic [15:0] bb, output int lat);
    z     = zz;
    b     = bb;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    z     = 32'd0;
    b     = 16'd0;
    #3;
    checks++;
    if ({q, r, busy, done, dbz} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0", q, r, busy, done, dbz);
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int lat;
    z     = 32'h0000FE01;
    b     = 16'h00FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_after_e0: got %b want 1", busy);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 32) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 32", lat);
    end
    checks++;
    if ({q, r, dbz, busy} !== {32'h000000FF, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_result: got q=%h r=%h dbz=%b busy=%b want q=000000ff r=0000 dbz=0 busy=1", q, r, dbz, busy);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_input_change();
    int lat;
    z     = 32'h00007C45;
    b     = 16'h00E0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    z = 32'h0;
    b = 16'h0001;
    checks++;
    if ({q, r} !== {32'h000000FF, 16'h0000}) begin
      errors++;
      $display("FAIL held_during_run: got q=%h r=%h want q=000000ff r=0000", q, r);
    end
    lat = -1;
    for (int n = 6; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 32) begin
      errors++;
      $display("FAIL change_latency: got %0d want 32", lat);
    end
    checks++;
    if ({q, r, dbz} !== {32'h0000008E, 16'h0005, 1'b0}) begin
      errors++;
      $display("FAIL change_result: got q=%h r=%h dbz=%b want q=0000008e r=0005 dbz=0", q, r, dbz);
    end
    tick();
  endtask

  task automatic test_hold();
    int lat;
    launch(32'hFFFFFFFF, 16'h0001, lat);
    checks++;
    if (lat != 32 || {q, r} !== {32'hFFFFFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL div_by_one: got lat=%0d q=%h r=%h want lat=32 q=ffffffff r=0000", lat, q, r);
    end
    repeat (4) tick();
    checks++;
    if ({q, r, busy} !== {32'hFFFFFFFF, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL hold_idle: got q=%h r=%h busy=%b want q=ffffffff r=0000 busy=0", q, r, busy);
    end
    launch(32'h00009240, 16'h00D0, lat);
    checks++;
    if (lat != 32 || {q, r, dbz} !== {32'h000000B4, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL second_run: got lat=%0d q=%h r=%h dbz=%b want lat=32 q=000000b4 r=0000 dbz=0", lat, q, r, dbz);
    end
    tick();
  endtask

  task automatic test_dbz();
    int lat;
    launch(32'h12345678, 16'h0000, lat);
    checks++;
    if (lat != DBZ_LAT) begin
      errors++;
      $display("FAIL dbz_latency: got %0d want %0d", lat, DBZ_LAT);
    end
    checks++;
    if ({q, r, dbz} !== {32'hFFFFFFFF, 16'h5678, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result: got q=%h r=%h dbz=%b want q=ffffffff r=5678 dbz=1", q, r, dbz);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    z     = 32'hDEADBEEF;
    b     = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({q, r, busy, done, dbz} !== 51'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b want all 0", q, r, busy, done, dbz);
    end
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_no_done: got done seen=%b want 0", seen);
    end
    reset = 1'b1;
    z     = 32'd100;
    b     = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept: got busy=%b want 1", busy);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 32 || {q, r, dbz} !== {32'd14, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_result: got lat=%0d q=%0d r=%0d dbz=%b want lat=32 q=14 r=2 dbz=0", lat, q, r, dbz);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int ndone;
    int nidle;
    int first_done;
    int bad_gap;
    int last_done;
    ndone      = 0;
    nidle      = 0;
    first_done = -1;
    last_done  = -1;
    bad_gap    = 0;
    z     = 32'h0000FE01;
    b     = 16'h00FF;
    start = 1'b1;
    for (int e = 1; e <= 110; e++) begin
      tick();
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = e;
        else if (e - last_done != 34) bad_gap++;
        last_done = e;
      end
      if (!busy) nidle++;
    end
    start = 1'b0;
    checks++;
    if (ndone != 3 || first_done != 33 || bad_gap != 0) begin
      errors++;
      $display("FAIL b2b_done_pulses: got count=%0d first=%0d bad_gaps=%0d want count=3 first=33 bad_gaps=0", ndone, first_done, bad_gap);
    end
    checks++;
    if (nidle != 3) begin
      errors++;
      $display("FAIL b2b_idle_cycles: got %0d want 3", nidle);
    end
    checks++;
    if ({q, r, dbz} !== {32'h000000FF, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result: got q=%h r=%h dbz=%b want q=000000ff r=0000 dbz=0", q, r, dbz);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_input_change();
    test_hold();
    test_dbz();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divu_32by16.md
DIVU_32BY16 -- requirements
Module: divu_32by16

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 z  input  32  unsigned dividend, sampled with start.
REQ-006 b  input  16  unsigned divisor, sampled with start.
REQ-007 q  output  32  unsigned quotient, registered.
REQ-008 r  output  16  unsigned remainder, registered.
REQ-009 busy  output  1  high while the operation is in RUN or DONE.
REQ-010 done  output  1  one-cycle pulse when q/r/dbz become valid.
REQ-011 dbz  output  1  divide-by-zero flag, valid with done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL latch z and b, clear the 17-bit partial remainder and the step counter, and enter RUN.
REQ-014 RUN SHALL perform one restoring shift-subtract step per clock.
  - rem = {rem[15:0], next dividend MSB}.
  - If rem >= {1'b0,b}: rem -= b and the quotient bit is 1; otherwise the quotient bit is 0.
REQ-015 RUN SHALL execute exactly 32 steps on edges E1..E32, then enter DONE at E32 with q and r updated at that same edge.
REQ-016 done SHALL be 1 only while in DONE, for exactly one cycle. The block SHALL then return to IDLE.
REQ-017 The result SHALL be the exact integer division: q = floor(z/b), r = z mod b, with r < b whenever b != 0.
REQ-018 q, r and dbz SHALL hold their values from done until the next accepted start; they SHALL NOT change during a later RUN.
REQ-019 busy SHALL be 1 from the edge after E0 through the DONE cycle, and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1. Changes on z or b during RUN SHALL NOT affect the result.
REQ-021 For b=0, the result SHALL be q=32'hFFFFFFFF, r=z[15:0] and dbz=1. This is the natural restoring result.
REQ-022 For b != 0, dbz SHALL be 0.
REQ-023 If start=1 in the DONE cycle, it SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-024 While reset=0, regardless of clk:
  - the state SHALL be IDLE;
  - q, r, the partial remainder and the counter SHALL be 0;
  - busy, done and dbz SHALL be 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse. After release, the block SHALL accept start on the first clock edge.

Configuration
REQ-026 Macro DIVU_DBZ_FAST_EN SHALL control the divide-by-zero path.
  - Defined: b=0 at start SHALL skip RUN and enter DONE at E1, with q, r and dbz as in REQ-021.
  - Undefined: b=0 SHALL take the full 32-step RUN, with done at E32 and identical values.
  - For b != 0, the two builds SHALL be cycle-identical.

Verification
REQ-027 z=32'h0000FE01, b=16'h00FF, start pulse -> done exactly 32 edges after E0; q=32'h000000FF, r=16'h0000, dbz=0.
REQ-028 z=32'h00007C45, b=16'h00E0 -> q=32'h0000008E, r=16'h0005. Change z to 32'h0 mid-RUN -> result unchanged.
REQ-029 z=32'hFFFFFFFF, b=16'h0001 -> q=32'hFFFFFFFF, r=16'h0000. Then z=32'h00009240, b=16'h00D0 -> q=32'h000000B4, r=0. Held q/r remain stable between the two runs.
REQ-030 z=32'h12345678, b=16'h0000 -> q=32'hFFFFFFFF, r=16'h5678, dbz=1. done at E1 with DIVU_DBZ_FAST_EN defined; at E32 without.
REQ-031 Assert reset=0 at step 10 of a run, release after 3 cycles -> no done pulse; all outputs 0. A following start with z=32'd100, b=16'd7 -> q=32'd14, r=16'd2.
REQ-032 Hold start=1 continuously -> back-to-back operations accepted only in IDLE. Each run produces exactly one done pulse, and no start is accepted during RUN or DONE.
